arb_rr: RTL and testbench

Parametrised N-requester arbiter with registered one-hot grant, round-robin or fixed-priority selection, grant locking while the owner holds its request, and a hold-limit timeout that prevents starvation. It sits between N request sources (test/agent side) and a shared resource (DUT side), replacing the fixed 2-requester arbiter. Grant outputs are registered, so monitors can sample them on clock edges.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_if.sv | 35 +++
 rtl/arb_pick.sv | 60 ++++++
 rtl/arb_rr.sv | 121 ++++++++++++
 tb/tb_arb_rr.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin / fixed-priority arbiter.
//   arb_state_e : controller state (IDLE = no owner, BUSY = owner holds grant)
//   arb_mode_e  : selection policy driven on the mode input
//   HOLD_W      : width of the hold counter (covers MAX_HOLD up to 255)
//   idx_width() : grant index width for N requesters
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int unsigned HOLD_W = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_if.sv
// arb_if: request/grant bundle between N request sources and the arbiter.
//   mode        : 0 = round-robin, 1 = fixed priority (index 0 highest)
//   request     : per-requester request level
//   grant       : registered one-hot grant or all-zero
//   grant_valid : |grant
//   grant_id    : index of the owner, holds while grant_valid = 0
// Modports: master = request sources, slave = arbiter.
interface arb_if #(
    parameter int unsigned N  = 4,
    localparam int unsigned IW = arb_pkg::idx_width(N)
);

    logic          mode;
    logic [N-1:0]  request;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    modport master (
        output mode,
        output request,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  mode,
        input  request,
        output grant,
        output grant_valid,
        output grant_id
    );

endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection.
//   req   : request vector
//   ptr   : round-robin search start
//   mode  : 0 = search from ptr, 1 = search from index 0
//   excl  : requesters removed from this pick (current owner on forced release)
//   found : at least one eligible requester
//   idx   : winner index (0 when found = 0)
// The eligible vector is rotated so the search start lands at bit 0, a
// lowest-bit priority encoder picks the winner, and the offset is rotated back.
module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [N-1:0] eligible;
    logic [N-1:0] rotated;
    int unsigned  base;
    int unsigned  src;
    int unsigned  offset;
    int unsigned  winner;

    always_comb begin
        eligible = req & ~excl;
        base     = (mode == ARB_FIXED) ? 0 : 32'(ptr);

        rotated = '0;
        for (int unsigned i = 0; i < N; i++) begin
            src = i + base;
            if (src >= N) begin
                src = src - N;
            end
            rotated[i] = eligible[src];
        end

        found  = 1'b0;
        offset = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end

        winner = offset + base;
        if (winner >= N) begin
            winner = winner - N;
        end
        idx = found ? IW'(winner) : '0;
    end

endmodule

// File: rtl/arb_rr.sv
// arb_rr: N-requester arbiter with registered one-hot grant.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arb_if slave (mode, request in; grant, grant_valid, grant_id out)
// Parameters: N requesters (2..16), MAX_HOLD cycles an owner may keep the
// grant while others wait (1..255).
// An owner keeps the grant while its request is high; on release, or when
// the hold limit expires with a competitor pending, the next winner is
// loaded on the same edge so there is no idle cycle between owners.
module arb_rr
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    arb_if.slave bus
);

    localparam int unsigned     IW        = idx_width(N);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IW-1:0]   LAST_ID   = IW'(N - 1);

    arb_state_e        state, state_next;
    logic [N-1:0]      owner_grant, owner_grant_next;
    logic [IW-1:0]     owner_id, owner_id_next;
    logic [IW-1:0]     ptr, ptr_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

    logic [N-1:0]      excl;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [N-1:0]      pick_onehot;
    logic              do_load;

    // The owner is excluded from every pick while BUSY: on release its
    // request is already low, on forced release it must not win again.
    assign excl = (state == BUSY) ? owner_grant : '0;

    arb_pick #(.N(N)) u_pick (
        .req   (bus.request),
        .ptr   (ptr),
        .mode  (bus.mode),
        .excl  (excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        state_next       = state;
        owner_grant_next = owner_grant;
        owner_id_next    = owner_id;
        ptr_next         = ptr;
        hold_cnt_next    = hold_cnt;
        do_load          = 1'b0;

        unique case (state)
            IDLE: begin
                owner_grant_next = '0;
                if (pick_found) begin
                    do_load = 1'b1;
                end
            end
            BUSY: begin
                if (bus.request[owner_id]) begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end else if (pick_found) begin
                        do_load = 1'b1;
                    end
                    // else: saturated, keep grant until a competitor shows up
                end else if (pick_found) begin
                    do_load = 1'b1;
                end else begin
                    state_next       = IDLE;
                    owner_grant_next = '0;
                    hold_cnt_next    = '0;
                end
            end
            default: begin
                state_next       = IDLE;
                owner_grant_next = '0;
            end
        endcase

        if (do_load) begin
            state_next       = BUSY;
            owner_grant_next = pick_onehot;
            owner_id_next    = pick_idx;
            hold_cnt_next    = '0;
            ptr_next         = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_grant <= '0;
            owner_id    <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_next;
            owner_grant <= owner_grant_next;
            owner_id    <= owner_id_next;
            ptr         <= ptr_next;
            hold_cnt    <= hold_cnt_next;
        end
    end

    assign bus.grant       = owner_grant;
    assign bus.grant_valid = |owner_grant;
    assign bus.grant_id    = owner_id;

endmodule

// File: tb/tb_arb_rr.sv
// tb_arb_rr: self-checking bench for arb_rr.
// dut4: N=4, MAX_HOLD=4.  dut2: N=2, MAX_HOLD=4 (mode change and ptr wrap).
// Each step drives inputs on the falling edge, pushes the expected grant to
// a scoreboard queue, then pops and compares it 1 time unit after the
// following rising edge.
module tb_arb_rr;

    logic clk;
    logic rst_n;

    arb_if #(.N(4)) bus4 ();
    arb_if #(.N(2)) bus2 ();

    arb_rr #(.N(4), .MAX_HOLD(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    arb_rr #(.N(2), .MAX_HOLD(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int unsigned n_checks;
    int unsigned n_errors;
    logic [15:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh_idx(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 32'(i);
        end
        return 32'd0;
    endfunction

    task automatic step4(input logic [3:0] req, input logic m, input logic [3:0] exp, input string tag);
        logic [15:0] e;
        @(negedge clk);
        bus4.request = req;
        bus4.mode    = m;
        sb.push_back(16'(exp));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".grant"}, 32'(bus4.grant), 32'(e));
        check({tag, ".valid"}, 32'(bus4.grant_valid), 32'(|e));
        if (e != 0) begin
            check({tag, ".id"}, 32'(bus4.grant_id), oh_idx(e));
        end
    endtask

    task automatic step2(input logic [1:0] req, input logic m, input logic [1:0] exp, input string tag);
        logic [15:0] e;
        @(negedge clk);
        bus2.request = req;
        bus2.mode    = m;
        sb.push_back(16'(exp));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".grant"}, 32'(bus2.grant), 32'(e));
        check({tag, ".valid"}, 32'(bus2.grant_valid), 32'(|e));
        if (e != 0) begin
            check({tag, ".id"}, 32'(bus2.grant_id), oh_idx(e));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp4;
        n_checks = 0;
        n_errors = 0;
        rst_n        = 1'b0;
        bus4.request = '0;
        bus4.mode    = 1'b0;
        bus2.request = '0;
        bus2.mode    = 1'b0;

        // reset state, before any clock edge
        #3;
        check("rst.grant", 32'(bus4.grant), 32'd0);
        check("rst.valid", 32'(bus4.grant_valid), 32'd0);
        check("rst.id", 32'(bus4.grant_id), 32'd0);
        check("rst.ptr", 32'(dut4.ptr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin rotation, every owner held exactly 4 cycles
        for (int g = 0; g < 5; g++) begin
            exp4 = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                step4(4'b1111, 1'b0, exp4, "rr");
            end
        end
        step4(4'b0000, 1'b0, 4'b0000, "rr_drop");

        // single request, then drop; grant_id holds
        step4(4'b0010, 1'b0, 4'b0010, "single");
        step4(4'b0000, 1'b0, 4'b0000, "single_drop");
        check("single_id_hold", 32'(bus4.grant_id), 32'd1);

        // fixed priority with timeout
        for (int b = 0; b < 3; b++) begin
            exp4 = (b == 1) ? 4'b0100 : 4'b0001;
            for (int c = 0; c < 4; c++) begin
                step4(4'b0101, 1'b1, exp4, "fixed");
            end
        end
        step4(4'b0000, 1'b1, 4'b0000, "fixed_drop");

        // saturated hold, then late competitor takes over on next edge
        for (int c = 0; c < 10; c++) begin
            step4(4'b0001, 1'b0, 4'b0001, "sat");
        end
        step4(4'b1001, 1'b0, 4'b1000, "sat_handoff");
        step4(4'b1001, 1'b0, 4'b1000, "sat_keep");
        // owner releases while another waits: handoff with no bubble
        step4(4'b0001, 1'b0, 4'b0001, "release_handoff");
        step4(4'b0000, 1'b0, 4'b0000, "release_idle");

        // asynchronous reset mid-grant
        step4(4'b0100, 1'b0, 4'b0100, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.grant", 32'(bus4.grant), 32'd0);
        check("mid_rst.valid", 32'(bus4.grant_valid), 32'd0);
        check("mid_rst.id", 32'(bus4.grant_id), 32'd0);
        check("mid_rst.ptr", 32'(dut4.ptr), 32'd0);
        bus4.request = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step4(4'b0110, 1'b0, 4'b0010, "post_rst");
        step4(4'b0000, 1'b0, 4'b0000, "post_rst_drop");

        // N=2: ptr wrap and mode change mid-hold
        step2(2'b10, 1'b0, 2'b10, "n2_first");
        check("n2_ptr_wrap", 32'(dut2.ptr), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step2(2'b11, 1'b1, 2'b10, "n2_mode_hold");
        end
        step2(2'b11, 1'b1, 2'b01, "n2_timeout");
        check("n2_ptr", 32'(dut2.ptr), 32'd1);
        step2(2'b01, 1'b1, 2'b01, "n2_keep");
        step2(2'b00, 1'b1, 2'b00, "n2_drop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
